// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

   // ALU operand source select, as driven onto ForwardAE / ForwardBE
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

   // Memory-sequencing state of the controller
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      ERROR    = 2'b10
   } hz_state_t;

   // ResultSrcE encoding that marks a load in Execute
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Selects the ALU operand sources in Execute from the in-flight writers in Memory and Writeback.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the register indices directly.
module forward_unit
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0] Rs1E,
   input  logic [ADDR_WIDTH-1:0] Rs2E,
   input  logic [ADDR_WIDTH-1:0] RdM,
   input  logic [ADDR_WIDTH-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   output fwd_sel_t              fwd_a,
   output fwd_sel_t              fwd_b
);

   // x0 is never a real producer, so a zero destination never forwards.
   // The Memory-stage writer is younger, so it overrides Writeback.
   function automatic fwd_sel_t pick(input logic [ADDR_WIDTH-1:0] rs);
      fwd_sel_t sel;
      sel = FWD_NONE;
      if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
         sel = FWD_MEM;
      end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   // Resolve both operands with the same priority rule
   always_comb begin
      fwd_a = pick(Rs1E);
      fwd_b = pick(Rs2E);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward controller for the 5-stage pipeline with a data-memory wait FSM and perf counters.
// Latency: hazard inputs reach stall/flush/forward outputs in zero cycles; counters and mem_error update on the next edge.
// Backpressure: a data access not acked freezes F/D/E/M and bubbles W until mem_ack, or forever after a timeout.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] Rs1D,
   input  logic [ADDR_WIDTH-1:0] Rs2D,
   input  logic [ADDR_WIDTH-1:0] Rs1E,
   input  logic [ADDR_WIDTH-1:0] Rs2E,
   input  logic [ADDR_WIDTH-1:0] RdE,
   input  logic [ADDR_WIDTH-1:0] RdM,
   input  logic [ADDR_WIDTH-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic [1:0]            ResultSrcE,
   input  logic                  PCSrcE,
   input  logic                  MemAccessM,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic                  mem_error,
   output logic [CNT_WIDTH-1:0]  stall_cycles,
   output logic [CNT_WIDTH-1:0]  flush_count
);

   // The wait counter only has to hold 0..TIMEOUT-1: the TIMEOUT-th
   // un-acked wait cycle is recognised by the counter sitting at its last value.
   localparam int             WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   hz_state_t      state;
   hz_state_t      state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           req_fsm;
   logic           mem_stall;
   logic           lw_stall;
   fwd_sel_t       fwd_a;
   fwd_sel_t       fwd_b;

   forward_unit #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_forward_unit (
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b)
   );

   // Load in Execute whose destination is read by the instruction in Decode
   assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Wait-cycle counter: cleared outside MEM_WAIT, counts each un-acked wait cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state != MEM_WAIT) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LAST) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Next-state logic; an ack arriving on the last allowed wait cycle still completes
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (MemAccessM && !mem_ack) begin
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               state_nxt = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ERROR;
            end
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // FSM outputs: memory request and the pipeline-freeze condition
   always_comb begin
      req_fsm   = 1'b0;
      mem_stall = 1'b0;
      case (state)
         RUN: begin
            req_fsm   = MemAccessM;
            mem_stall = MemAccessM && !mem_ack;
         end
         MEM_WAIT: begin
            req_fsm   = 1'b1;
            mem_stall = !mem_ack;
         end
         ERROR: begin
            req_fsm   = 1'b0;
            mem_stall = 1'b1;
         end
         default: begin
            req_fsm   = 1'b0;
            mem_stall = 1'b0;
         end
      endcase
   end

   assign mem_error = (state == ERROR);
   assign mem_req   = req_fsm && !rst;
   assign ForwardAE = rst ? FWD_NONE : fwd_a;
   assign ForwardBE = rst ? FWD_NONE : fwd_b;

   // Stall/flush priority: reset forcing, then memory freeze, then branch over load-use.
   // While frozen, Execute holds its instruction, so a pending branch or load-use
   // simply re-evaluates once the access completes.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (rst) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall && !PCSrcE;
         StallD = lw_stall && !PCSrcE;
         FlushD = PCSrcE;
         FlushE = lw_stall || PCSrcE;
      end
   end

   // Saturating count of fetch-stall cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (StallF && !(&stall_cycles)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   // Saturating count of taken-branch flushes that actually reached Decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_count <= '0;
      end else if (FlushD && !(&flush_count)) begin
         flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomised and directed bench for pipeline_hazard_controller against a behavioural model.
// Latency: model predicts combinational outputs per cycle and counters/flags per edge.
// Backpressure: mem_ack is driven randomly to exercise waits, timeouts and recoveries.
module tb_pipeline_hazard_controller;

   localparam int AW   = 5;
   localparam int TO   = 4;
   localparam int CW   = 6;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          RegWriteM, RegWriteW;
   logic [1:0]    ResultSrcE;
   logic          PCSrcE, MemAccessM, mem_ack;
   logic          mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_error;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] stall_cycles, flush_count;

   int errs   = 0;
   int checks = 0;

   // Behavioural model state: waited = cycles already spent waiting on an
   // outstanding access (-1 when none), err = watchdog has fired.
   int waited = -1;
   bit err    = 1'b0;
   int m_sc   = 0;
   int m_fc   = 0;

   // Expected outputs for the current cycle
   logic       e_req, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_err;
   logic [1:0] e_fa, e_fb;

   pipeline_hazard_controller #(
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TO),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .Rs1D         (Rs1D),
      .Rs2D         (Rs2D),
      .Rs1E         (Rs1E),
      .Rs2E         (Rs2E),
      .RdE          (RdE),
      .RdM          (RdM),
      .RdW          (RdW),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .ResultSrcE   (ResultSrcE),
      .PCSrcE       (PCSrcE),
      .MemAccessM   (MemAccessM),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushW       (FlushW),
      .mem_error    (mem_error),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Derive this cycle's outputs from the model state and current inputs
   function automatic void compute();
      logic frozen, lw;
      if (err) begin
         e_req = 1'b0; frozen = 1'b1;
      end else if (waited >= 0) begin
         e_req = 1'b1; frozen = !mem_ack;
      end else begin
         e_req = MemAccessM; frozen = MemAccessM && !mem_ack;
      end
      lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      e_err = err;
      e_fa  = exp_fwd(Rs1E);
      e_fb  = exp_fwd(Rs2E);
      if (frozen) begin
         {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
         {e_fd, e_fe} = 2'b00;
      end else begin
         e_sf = lw && !PCSrcE; e_sd = e_sf; e_se = 1'b0; e_sm = 1'b0; e_fw = 1'b0;
         e_fd = PCSrcE; e_fe = lw || PCSrcE;
      end
      if (rst) begin
         e_req = 1'b0; e_err = 1'b0; e_fa = 2'b00; e_fb = 2'b00;
         {e_sf, e_sd, e_se, e_sm} = 4'b0000;
         {e_fd, e_fe, e_fw} = 3'b111;
      end
   endfunction

   // Model update at each edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         waited = -1; err = 1'b0; m_sc = 0; m_fc = 0;
      end else begin
         compute();
         if (e_sf && m_sc < MAXC) m_sc++;
         if (e_fd && m_fc < MAXC) m_fc++;
         if (!err) begin
            if (waited >= 0) begin
               if (mem_ack) waited = -1;
               else if (waited + 1 == TO) begin err = 1'b1; waited = -1; end
               else waited++;
            end else if (MemAccessM && !mem_ack) begin
               waited = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      compute();
      chk("mem_req",   32'(mem_req),   32'(e_req));
      chk("ForwardAE", 32'(ForwardAE), 32'(e_fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(e_fb));
      chk("StallF",    32'(StallF),    32'(e_sf));
      chk("StallD",    32'(StallD),    32'(e_sd));
      chk("StallE",    32'(StallE),    32'(e_se));
      chk("StallM",    32'(StallM),    32'(e_sm));
      chk("FlushD",    32'(FlushD),    32'(e_fd));
      chk("FlushE",    32'(FlushE),    32'(e_fe));
      chk("FlushW",    32'(FlushW),    32'(e_fw));
      chk("mem_error", 32'(mem_error), 32'(e_err));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
      chk("flush_count",  32'(flush_count),  32'(m_fc));
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clr();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MemAccessM = 0; mem_ack = 0;
   endtask

   initial begin
      rst = 1'b1;
      clr();
      mid();
      chk("rst_flushd", 32'(FlushD), 32'd1);
      chk("rst_flushw", 32'(FlushW), 32'd1);
      chk("rst_stallf", 32'(StallF), 32'd0);
      chk("rst_req",    32'(mem_req), 32'd0);
      nxt(); rst = 1'b0;

      // Forwarding priority
      RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
      mid(); chk("fwd_mem", 32'(ForwardAE), 32'd2); chk("fwd_mem_b", 32'(ForwardBE), 32'd2);
      nxt(); RegWriteM = 0;
      mid(); chk("fwd_wb", 32'(ForwardAE), 32'd1);
      nxt(); Rs1E = 0; RdM = 0; RdW = 0;
      mid(); chk("fwd_x0", 32'(ForwardAE), 32'd0);

      // Load-use
      nxt(); clr(); ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
      mid(); chk("lu_stallf", 32'(StallF), 32'd1); chk("lu_flushe", 32'(FlushE), 32'd1);
      chk("lu_flushd", 32'(FlushD), 32'd0);
      nxt(); clr();
      mid(); chk("lu_cnt", 32'(stall_cycles), 32'd1);

      // Taken branch
      nxt(); PCSrcE = 1;
      mid(); chk("br_flushd", 32'(FlushD), 32'd1); chk("br_stallf", 32'(StallF), 32'd0);
      chk("br_cnt0", 32'(flush_count), 32'd0);
      nxt(); clr();
      mid(); chk("br_cnt1", 32'(flush_count), 32'd1);

      // Memory wait: three un-acked cycles, then ack
      nxt(); MemAccessM = 1;
      for (int i = 0; i < 3; i++) begin
         mid(); chk("mw_stallm", 32'(StallM), 32'd1); chk("mw_req", 32'(mem_req), 32'd1);
         nxt();
      end
      mem_ack = 1;
      mid(); chk("mw_ack_req", 32'(mem_req), 32'd1); chk("mw_ack_stallf", 32'(StallF), 32'd0);
      nxt(); clr();
      mid(); chk("mw_cnt", 32'(stall_cycles), 32'd4); chk("mw_req_off", 32'(mem_req), 32'd0);

      // Branch masked by the memory freeze
      nxt(); MemAccessM = 1; PCSrcE = 1;
      mid(); chk("mask_flushd", 32'(FlushD), 32'd0);
      nxt();
      mid(); chk("mask_flushd2", 32'(FlushD), 32'd0);
      nxt(); mem_ack = 1;
      mid(); chk("mask_release", 32'(FlushD), 32'd1);
      nxt(); clr();
      mid(); chk("mask_fcnt", 32'(flush_count), 32'd2); chk("mask_scnt", 32'(stall_cycles), 32'd6);

      // Timeout into ERROR, then async reset
      nxt(); MemAccessM = 1;
      for (int i = 0; i < 4; i++) nxt();
      mid(); chk("to_last_err", 32'(mem_error), 32'd0); chk("to_last_req", 32'(mem_req), 32'd1);
      nxt();
      mid(); chk("to_err", 32'(mem_error), 32'd1); chk("to_req", 32'(mem_req), 32'd0);
      chk("to_stallm", 32'(StallM), 32'd1);
      nxt(); MemAccessM = 0;
      mid(); chk("to_held", 32'(StallF), 32'd1);
      nxt(); #2 rst = 1'b1; #1;
      chk("arst_err", 32'(mem_error), 32'd0); chk("arst_sc", 32'(stall_cycles), 32'd0);
      chk("arst_fc", 32'(flush_count), 32'd0); chk("arst_fw", 32'(FlushW), 32'd1);
      nxt(); rst = 1'b0;

      // Ack on the last allowed wait cycle still completes
      MemAccessM = 1;
      for (int i = 0; i < 4; i++) nxt();
      mem_ack = 1;
      nxt(); clr();
      mid(); chk("lastack_err", 32'(mem_error), 32'd0); chk("lastack_stall", 32'(StallF), 32'd0);

      // Reset mid-wait drops the request immediately
      nxt(); MemAccessM = 1;
      nxt();
      mid(); chk("mwr_req_on", 32'(mem_req), 32'd1);
      nxt(); #2 rst = 1'b1; #1;
      chk("mwr_req_off", 32'(mem_req), 32'd0); chk("mwr_stallf", 32'(StallF), 32'd0);
      nxt(); rst = 1'b0; clr();

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         nxt();
         rst        = ($urandom_range(0, 99) < 2);
         Rs1D       = AW'($urandom_range(0, 3));
         Rs2D       = AW'($urandom_range(0, 3));
         Rs1E       = AW'($urandom_range(0, 3));
         Rs2E       = AW'($urandom_range(0, 3));
         RdE        = AW'($urandom_range(0, 3));
         RdM        = AW'($urandom_range(0, 3));
         RdW        = AW'($urandom_range(0, 3));
         RegWriteM  = $urandom_range(0, 1) == 1;
         RegWriteW  = $urandom_range(0, 1) == 1;
         ResultSrcE = 2'($urandom_range(0, 3));
         PCSrcE     = $urandom_range(0, 99) < 15;
         MemAccessM = $urandom_range(0, 99) < 40;
         mem_ack    = $urandom_range(0, 99) < 35;
      end
      nxt(); rst = 1'b0; clr();
      mid();
      #1;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
